mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response bundle between a memory initiator and
//               mem_responder. The master drives the request and the slave
//               answers with a single-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-organised memory target with a fixed number of wait
//               states. Each accepted request is latched, delayed, then
//               answered with a one-cycle mem_ready pulse carrying read data
//               or an out-of-range error. Storage is never reset.
// Options     : MEM_RESPONDER_RANDWAIT_EN - adds an 8-bit LFSR whose two low
//               bits extend the wait count of each request.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input wire logic       clock,
  input wire logic       reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 5;  // holds 15 + 3 when the random extension is on

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [31:0]      ERR_DATA  = 32'hDEAD_BEEF;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [29:0]      addr_q;   // word address, byte offset dropped
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             accept;
  logic             finish;
  logic             in_range;
  logic             wr_en;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] load_cnt;

  // Fetch type carries no meaning for this target.
  logic unused_instr;
  assign unused_instr = bus.mem_instr;

  assign accept   = (state_q == S_IDLE) && bus.mem_valid;
  assign finish   = (state_q == S_WAIT) && (cnt_q == '0);
  assign in_range = addr_q < 30'(DEPTH_WORDS);
  assign idx      = addr_q[IDX_W-1:0];
  // Gating with reset keeps an aborted transaction from touching storage.
  assign wr_en    = finish && in_range && (wstrb_q != 4'b0000) && !reset;

`ifdef MEM_RESPONDER_RANDWAIT_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign load_cnt = WAIT_INIT + {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};

  // Fibonacci LFSR (taps 8,6,5,4), stepped once per accepted request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end
`else
  assign load_cnt = WAIT_INIT;
`endif

  // State register plus the registered response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_valid) begin
          state_d = S_WAIT;
          cnt_d   = load_cnt;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Response values, loaded on the edge that enters RESP and zero otherwise.
  always_comb begin
    ready_d = 1'b0;
    rdata_d = 32'h0000_0000;
    err_d   = 1'b0;
    if (finish) begin
      ready_d = 1'b1;
      if (!in_range) begin
        rdata_d = ERR_DATA;
        err_d   = 1'b1;
      end else if (wstrb_q == 4'b0000) begin
        rdata_d = mem_q[idx];
      end
    end
  end

  // Request capture; later bus changes are ignored until the next accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'b0000;
    end else if (accept) begin
      addr_q  <= bus.mem_addr[31:2];
      wdata_q <= bus.mem_wdata;
      wstrb_q <= bus.mem_wstrb;
    end
  end

  // Byte-masked storage write on the edge entering RESP.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder. Two instances run side by
//               side: dut2 with WAIT_CYCLES=2 and dut0 with WAIT_CYCLES=0.
//               Drivers push expected responses; per-instance monitors pop
//               and compare whenever mem_ready is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          start;
    int          lat;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;
  bit   prev_rdy [2];
  logic [7:0] lf [2];

  exp_t exp_q0[$];
  exp_t exp_q2[$];

  mem_responder_if bus0 ();
  mem_responder_if bus2 ();

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected latency for the next request on instance s, advancing the model LFSR.
  task automatic next_lat(input int s, output int lat);
    logic [7:0] l;
    lat = (s == 0) ? 2 : 4;
    l = lf[s];
`ifdef MEM_RESPONDER_RANDWAIT_EN
    lat = lat + int'(l[1:0]);
`endif
    lf[s] = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endtask

  task automatic drive(input int s, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws, input logic ins);
    if (s == 0) begin
      bus0.mem_valid = v; bus0.mem_addr = a; bus0.mem_wdata = wd;
      bus0.mem_wstrb = ws; bus0.mem_instr = ins;
    end else begin
      bus2.mem_valid = v; bus2.mem_addr = a; bus2.mem_wdata = wd;
      bus2.mem_wstrb = ws; bus2.mem_instr = ins;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? bus0.mem_ready : bus2.mem_ready;
  endfunction

  // Issue one request (called at posedge+1) and wait for its ready pulse.
  task automatic req(input int s, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic ins,
                     input logic [31:0] exp_rd, input logic exp_er, input bit scramble);
    exp_t e;
    bit   got;
    drive(s, 1'b1, a, wd, ws, ins);
    e.rdata = exp_rd;
    e.err   = exp_er;
    e.start = cyc;
    next_lat(s, e.lat);
    if (s == 0) exp_q0.push_back(e); else exp_q2.push_back(e);
    @(posedge clock); #1;
    if (scramble) drive(s, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      got = rdy(s);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout dut%0d addr=%h: no mem_ready within 40 cycles", s, a);
      if (s == 0) void'(exp_q0.pop_back()); else void'(exp_q2.pop_back());
    end
    @(posedge clock); #1;
    drive(s, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic mon_check(input int s, input logic r, input logic [31:0] rd, input logic er);
    exp_t e;
    bit   have;
    if (!mon_en) return;
    if (r) begin
      checks++;
      if (prev_rdy[s]) begin
        failures++;
        $display("FAIL pulse_width dut%0d: mem_ready high on consecutive cycles, required single pulse", s);
      end
      have = 1'b0;
      if (s == 0) begin
        if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      end else begin
        if (exp_q2.size() != 0) begin e = exp_q2.pop_front(); have = 1'b1; end
      end
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL unexpected_ready dut%0d: mem_ready=1 with no request outstanding", s);
      end else begin
        if (rd !== e.rdata || er !== e.err) begin
          failures++;
          $display("FAIL response dut%0d: rdata=%h err=%b, required rdata=%h err=%b",
                   s, rd, er, e.rdata, e.err);
        end
        checks++;
        if (cyc - e.start != e.lat) begin
          failures++;
          $display("FAIL latency dut%0d: got %0d cycles, required %0d", s, cyc - e.start, e.lat);
        end
      end
    end else begin
      checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs dut%0d: rdata=%h err=%b, required 0/0", s, rd, er);
      end
    end
    prev_rdy[s] = r;
  endtask

  always @(negedge clock) mon_check(0, bus0.mem_ready, bus0.mem_rdata, bus0.mem_err);
  always @(negedge clock) mon_check(2 - 1, bus2.mem_ready, bus2.mem_rdata, bus2.mem_err);

  task automatic check_reset_state(input string nm);
    checks++;
    if (bus2.mem_ready !== 1'b0 || bus2.mem_rdata !== 32'h0 || bus2.mem_err !== 1'b0 ||
        bus0.mem_ready !== 1'b0 || bus0.mem_rdata !== 32'h0 || bus0.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL %s: dut2 ready/rdata/err=%b/%h/%b dut0=%b/%h/%b, required all zero",
               nm, bus2.mem_ready, bus2.mem_rdata, bus2.mem_err,
               bus0.mem_ready, bus0.mem_rdata, bus0.mem_err);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0; mon_en = 1'b0;
    prev_rdy[0] = 1'b0; prev_rdy[1] = 1'b0;
    lf[0] = 8'hA5; lf[1] = 8'hA5;
    reset = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_state("reset_state");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic write/read and byte-strobe merge on the WAIT_CYCLES=2 instance.
    req(1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    req(1, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    req(1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, 1'b0, 1'b0);
    req(1, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h12BB_56DD, 1'b0, 1'b0);
    req(1, 32'h0000_0013, 32'h0,         4'h0, 1'b0, 32'h12BB_56DD, 1'b0, 1'b0);
    req(1, 32'h0000_0000, 32'h0000_1111, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    req(1, 32'h0000_03FC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    req(1, 32'h0000_03FC, 32'h0,         4'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Out-of-range read and write; word 0 would alias if the range check were lost.
    req(1, 32'h0000_0400, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    req(1, 32'h0000_0400, 32'h7777_7777, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    req(1, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h0000_1111, 1'b0, 1'b0);
    req(1, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'h12BB_56DD, 1'b0, 1'b0);

    // Bus changes after acceptance must not affect the latched request.
    req(1, 32'h0000_0014, 32'h5555_AAAA, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
    req(1, 32'h0000_0014, 32'h0,         4'h0, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0);
    req(1, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'h12BB_56DD, 1'b0, 1'b0);

    // Reset in WAIT aborts a write without touching storage.
    req(1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1'b0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    #1 check_reset_state("abort_state");
    lf[0] = 8'hA5; lf[1] = 8'hA5;
    @(posedge clock); #1;
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(posedge clock); #1;
    check_reset_state("reset_held");
    reset = 1'b0;
    req(1, 32'h0000_0020, 32'h0,         4'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Back-to-back traffic on the WAIT_CYCLES=0 instance.
    req(0, 32'h0000_0000, 32'h0000_0001, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    req(0, 32'h0000_0004, 32'h0000_0002, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    req(0, 32'h0000_0008, 32'h0000_0003, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    req(0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    req(0, 32'h0000_0004, 32'h0,         4'h0, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    req(0, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 32'h0000_0003, 1'b0, 1'b0);

    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (exp_q0.size() != 0 || exp_q2.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", exp_q0.size(), exp_q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
